// File: rtl/demux_12_4b_pkg.sv
// Shared definitions for the 1-to-2 nibble demux: FSM encoding, widths and
// the saturating increment used by the optional pair counter.
package demux_12_4b_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_HAVE0 = 2'b01;
    localparam logic [1:0] ST_HAVE1 = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    // Holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/demux_12_4b_reg_slot.sv
// slot_reg_4b: one nibble holding register with asynchronous active-low clear
// and a synchronous load enable.
module slot_reg_4b
    import demux_12_4b_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/demux_12_4b_reg.sv
// demux_12_4b_reg: steers nibbles into slot D0/D1 and presents the pair once
// both are loaded. Optional pair counter enabled by DEMUX_12_4B_REG_PAIR_CNT_EN.
module demux_12_4b_reg
    import demux_12_4b_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_d0,
    output logic [DATA_W-1:0] out_d1,
`ifdef DEMUX_12_4B_REG_PAIR_CNT_EN
    output logic [CNT_W-1:0]  pair_cnt,
`endif
    input  logic              out_ready
);

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       w_accept;
    logic       w_load0;
    logic       w_load1;
    logic       w_pair_done;

    // Handshake signals decode only the state register, never the inputs.
    assign in_ready    = (r_state != ST_FULL);
    assign out_valid   = (r_state == ST_FULL);
    assign w_accept    = in_valid && in_ready;
    assign w_load0     = w_accept && !in_sel;
    assign w_load1     = w_accept &&  in_sel;
    assign w_pair_done = out_valid && out_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = in_sel ? ST_HAVE1 : ST_HAVE0;
                end
            end
            ST_HAVE0: begin
                // A repeat sel 0 just overwrites D0 and stays here.
                if (w_load1) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_HAVE1: begin
                if (w_load0) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_pair_done) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    slot_reg_4b u_slot_d0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load0),
        .i_d    (in_data),
        .o_q    (out_d0)
    );

    slot_reg_4b u_slot_d1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load1),
        .i_d    (in_data),
        .o_q    (out_d1)
    );

`ifdef DEMUX_12_4B_REG_PAIR_CNT_EN
    logic [CNT_W-1:0] r_pair_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair_cnt <= '0;
        end else if (w_pair_done) begin
            r_pair_cnt <= sat_inc(r_pair_cnt);
        end
    end

    assign pair_cnt = r_pair_cnt;
`endif

endmodule

// File: tb/tb_demux_12_4b_reg.sv
// Directed bench for demux_12_4b_reg: expected pairs go into a queue and a
// monitor compares them at each pair handshake; state checks run inline.
module tb_demux_12_4b_reg;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_sel;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_d0;
    logic [3:0] out_d1;
    logic       out_ready;
`ifdef DEMUX_12_4B_REG_PAIR_CNT_EN
    logic [7:0] pair_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    demux_12_4b_reg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_d0    (out_d0),
        .out_d1    (out_d1),
`ifdef DEMUX_12_4B_REG_PAIR_CNT_EN
        .pair_cnt  (pair_cnt),
`endif
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic sel, input logic [3:0] data);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_outs(input string name, input logic v, input logic r,
                            input logic [3:0] d0, input logic [3:0] d1);
        chk({name, ".out_valid"}, {7'd0, out_valid}, {7'd0, v});
        chk({name, ".in_ready"},  {7'd0, in_ready},  {7'd0, r});
        chk({name, ".out_d0"},    {4'd0, out_d0},    {4'd0, d0});
        chk({name, ".out_d1"},    {4'd0, out_d1},    {4'd0, d1});
    endtask

    // Scoreboard monitor: a pair completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pair_unexpected: got %h%h expected none", out_d0, out_d1);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("pair", {out_d0, out_d1}, e);
                $display("pair d0=%h d1=%h expected %h", out_d0, out_d1, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int total;
        logic [3:0] a;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_sel    = 1'b0;
        out_ready = 1'b0;
        #12;
        chk_outs("reset", 1'b0, 1'b1, 4'h0, 4'h0);
`ifdef DEMUX_12_4B_REG_PAIR_CNT_EN
        chk("reset.pair_cnt", pair_cnt, 8'h00);
`endif
        rst_n = 1'b1;
        step();

        // Basic pair 3/A
        beat(1'b0, 4'h3);
        chk_outs("s1_have0", 1'b0, 1'b1, 4'h3, 4'h0);
        exp_q.push_back(8'h3A);
        beat(1'b1, 4'hA);
        chk_outs("s1_full", 1'b1, 1'b0, 4'h3, 4'hA);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_outs("s1_released", 1'b0, 1'b1, 4'h3, 4'hA);

        // Overwrite in HAVE0
        beat(1'b0, 4'h3);
        beat(1'b0, 4'h5);
        chk_outs("s2_overwrite", 1'b0, 1'b1, 4'h5, 4'hA);
        exp_q.push_back(8'h57);
        beat(1'b1, 4'h7);
        chk_outs("s2_full", 1'b1, 1'b0, 4'h5, 4'h7);

        // Stall in FULL with beats offered
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_sel   = i[0];
            in_data  = 4'hF;
            step();
            chk_outs("s3_stall", 1'b1, 1'b0, 4'h5, 4'h7);
        end
        // Beat offered on the release cycle is dropped
        in_sel    = 1'b0;
        in_data   = 4'h9;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk_outs("s3_release", 1'b0, 1'b1, 4'h5, 4'h7);

        // out_ready ignored outside FULL; then async reset in HAVE1
        beat(1'b1, 4'h4);
        chk_outs("s4_have1", 1'b0, 1'b1, 4'h5, 4'h4);
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_outs("s4_async_rst", 1'b0, 1'b1, 4'h0, 4'h0);
        #1 rst_n = 1'b1;
        beat(1'b0, 4'h2);
        chk_outs("s4_after_rst", 1'b0, 1'b1, 4'h2, 4'h0);
        exp_q.push_back(8'h26);
        beat(1'b1, 4'h6);
        chk_outs("s4_full", 1'b1, 1'b0, 4'h2, 4'h6);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total = 1;
`ifdef DEMUX_12_4B_REG_PAIR_CNT_EN
        chk("cnt_after_rst", pair_cnt, 8'h01);
`endif

        // 256 more pairs: counter saturates
        for (int i = 0; i < 256; i++) begin
            a = i[3:0];
            exp_q.push_back({a, ~a});
            beat(1'b1, ~a);
            beat(1'b0, a);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            total++;
`ifdef DEMUX_12_4B_REG_PAIR_CNT_EN
            if (total == 254) chk("cnt_254", pair_cnt, 8'hFE);
            if (total == 255) chk("cnt_255", pair_cnt, 8'hFF);
            if (total == 257) chk("cnt_257", pair_cnt, 8'hFF);
`endif
        end
        chk_outs("final", 1'b0, 1'b1, 4'hF, 4'h0);

        step();
        chk("queue_drained", exp_q.size(), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_12_4b_reg.md
DEMUX_12_4B_REG -- requirements
Module: demux_12_4b_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with these ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data/in_sel present this cycle.
- in_data  in  4  nibble to store.
- in_sel  in  1  slot select: 0 = slot D0, 1 = slot D1.
- in_ready  out  1  block can accept a nibble.
- out_valid  out  1  both slots hold data; pair presented.
- out_d0  out  4  registered slot D0.
- out_d1  out  4  registered slot D1.
- out_ready  in  1  consumer takes the pair.
- pair_cnt  out  8  pairs delivered; present only when PAIR_CNT_EN is defined.

Function
REQ-002 The block SHALL use a 4-state FSM: EMPTY, HAVE0 (only D0 loaded), HAVE1 (only D1 loaded), FULL.
REQ-003 An input beat SHALL be accepted when in_valid && in_ready at a rising clk edge.
REQ-004 in_ready SHALL be 1 in EMPTY, HAVE0 and HAVE1, and 0 in FULL.
REQ-005 An accepted beat SHALL load in_data into out_d0 (in_sel=0) or out_d1 (in_sel=1) on that edge, so the data is visible one cycle after acceptance.
REQ-006 FSM transitions SHALL be:
- EMPTY -> HAVE0 on sel 0; EMPTY -> HAVE1 on sel 1.
- HAVE0 -> FULL on sel 1; HAVE1 -> FULL on sel 0.
REQ-007 A beat that targets an already-loaded slot in HAVE0 or HAVE1 SHALL overwrite that slot, and the state SHALL not change.
REQ-008 out_valid SHALL be 1 exactly when the state is FULL; it is a registered decode with no combinational path from inputs.
REQ-009 In FULL, out_ready=1 at a clk edge SHALL complete the pair handshake, and the next state SHALL be EMPTY.
REQ-010 out_d0 and out_d1 SHALL hold their values after the handshake until they are overwritten.
REQ-011 While FULL and out_ready=0, out_d0, out_d1 and out_valid SHALL be stable.
REQ-012 An in_valid beat while in FULL SHALL be ignored (in_ready=0), with no data change.
REQ-013 There is no same-cycle pass-through: a beat presented in the cycle FULL is released SHALL be ignored and must be re-presented.
REQ-014 out_ready SHALL be ignored in every state other than FULL.

Reset
REQ-015 rst_n low SHALL immediately, without waiting for clk, force:
- state to EMPTY;
- out_d0 and out_d1 to 4'h0;
- out_valid to 0 and in_ready to 1;
- pair_cnt to 8'h00 when present.
REQ-016 Reset asserted mid-pair (HAVE0, HAVE1 or FULL) SHALL discard partial data; the first edge after deassertion SHALL behave as in EMPTY.

Configuration
REQ-017 With macro DEMUX_12_4B_REG_PAIR_CNT_EN defined, the pair_cnt port SHALL exist.
REQ-018 pair_cnt SHALL increment by 1 on each completed pair handshake and saturate at 8'hFF.
REQ-019 Without the macro, the pair_cnt port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-020 A shared package demux_12_4b_pkg SHALL hold:
- the FSM state encoding (EMPTY=2'b00, HAVE0=2'b01, HAVE1=2'b10, FULL=2'b11);
- the constants DATA_W=4 and CNT_W=8.
REQ-021 One sub-module, slot_reg_4b, SHALL provide a 4-bit register with async active-low clear and load enable; it is instantiated twice (D0 and D1).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then beat sel0 data 4'h3, then beat sel1 data 4'hA -> out_valid=1, out_d0=3, out_d1=A two cycles after the first beat.
- HAVE0 holding 4'h3, beat sel0 data 4'h5 -> out_d0=5, state HAVE0, out_valid=0.
- FULL with out_ready=0 for 5 cycles plus in_valid beats -> outputs unchanged, in_ready=0 throughout; out_ready=1 -> EMPTY next cycle.
- rst_n pulsed low between clk edges while in HAVE1 -> out_d1=0 and in_ready=1 before the next edge.
- PAIR_CNT_EN defined, 257 completed pairs -> pair_cnt=8'hFF; macro undefined -> the design compiles without the pair_cnt port.
